// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative MIPS multiply/divide unit owning the HI/LO registers
module mdu_hilo #(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(ITER);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t             state;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_r;
  logic               sa, sb, dz;
  logic [WIDTH-1:0]   opnd, a_raw;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   abs_a, abs_b, q, r, qf, rf;
  logic [WIDTH:0]     msum, dup, df;
  logic [2*WIDTH:0]   sh;
  logic               ge, neg;
  logic [2*WIDTH-1:0] mul_nx, div_nx, step_nx, mul_res, div_res, res;
  // operand magnitudes, one multiply/divide step, and the final sign fix-up
  always_comb begin
    abs_a   = (!op[0] && a[WIDTH-1]) ? -a : a;
    abs_b   = (!op[0] && b[WIDTH-1]) ? -b : b;
    msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    mul_nx  = {msum, acc[WIDTH-1:1]};
    sh      = {acc, 1'b0};
    dup     = sh[2*WIDTH:WIDTH];
    ge      = dup >= {1'b0, opnd};
    df      = dup - {1'b0, opnd};
    div_nx  = ge ? {df[WIDTH-1:0], sh[WIDTH-1:1], 1'b1} : sh[2*WIDTH-1:0];
    step_nx = op_r[1] ? div_nx : mul_nx;
    neg     = !op_r[0] && (sa ^ sb);
    mul_res = neg ? -acc : acc;
    q       = acc[WIDTH-1:0];
    r       = acc[2*WIDTH-1:WIDTH];
    qf      = neg ? -q : q;
    rf      = (!op_r[0] && sa) ? -r : r;
    div_res = dz ? {a_raw, {WIDTH{1'b1}}} : {rf, qf};
    res     = op_r[1] ? div_res : mul_res;
  end
  // control FSM, iteration state and the architectural HI/LO registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      op_r  <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      dz    <= 1'b0;
      opnd  <= '0;
      a_raw <= '0;
      acc   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r  <= op;
            sa    <= !op[0] && a[WIDTH-1];
            sb    <= !op[0] && b[WIDTH-1];
            dz    <= op[1] && (b == '0);
            a_raw <= a;
            opnd  <= op[1] ? abs_b : abs_a;
            acc   <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            if (mthi_we) hi <= wdata;
            if (mtlo_we) lo <= wdata;
          end
        end
        RUN: begin
          acc <= step_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) state <= FIX;
        end
        FIX: begin
          {hi, lo} <= res;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: scoreboard bench for the HI/LO multiply/divide unit
module tb_mdu_hilo;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        mthi_we = 1'b0, mtlo_we = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done;
  int          n_cmp = 0, n_err = 0, cyc = 0, t0 = 0;
  logic [63:0] sb_q[$];
  logic [31:0] old_lo;

  mdu_hilo dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, qq, rr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: model = sx * sy;
      2'b01: model = {32'b0, x} * {32'b0, y};
      2'b10: begin
        if (y == 0) model = {x, 32'hFFFFFFFF};
        else begin
          qq = sx / sy;
          rr = sx % sy;
          model = {rr[31:0], qq[31:0]};
        end
      end
      default: model = (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
    endcase
  endfunction

  // pop and compare whenever the DUT reports a finished operation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
      else chk("hilo", {hi, lo}, sb_q.pop_front());
    end
  end

  task automatic go(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    sb_q.push_back(model(o, x, y));
    @(posedge clk);
    #1 start = 1'b0;
    t0 = cyc;
    chk("busy_after_start", {63'b0, busy}, 64'd1);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("latency", 64'(cyc - t0 + 1), 64'd34);
    chk("busy_at_done", {63'b0, busy}, 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 chk("reset_state", {hi, lo, 30'b0, busy, done}, 96'd0);
    @(negedge clk) rst = 1'b0;

    go(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_done();
    chk("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
    @(posedge clk) #1 chk("done_one_cycle", {63'b0, done}, 64'd0);
    go(2'b00, 32'hFFFFFFFD, 32'd5); wait_done();
    chk("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    go(2'b10, 32'hFFFFFFF9, 32'd2); wait_done();
    chk("div_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    go(2'b11, 32'd100, 32'd7); wait_done();
    chk("divu", {hi, lo}, 64'h00000002_0000000E);
    go(2'b10, 32'h80000000, 32'hFFFFFFFF); wait_done();
    chk("div_ovf", {hi, lo}, 64'h00000000_80000000);
    go(2'b11, 32'h12345678, 32'd0); wait_done();
    chk("divu_zero", {hi, lo}, 64'h12345678_FFFFFFFF);
    go(2'b10, 32'h80000001, 32'd0); wait_done();
    chk("div_zero", {hi, lo}, 64'h80000001_FFFFFFFF);
    go(2'b10, 32'd7, 32'hFFFFFFFE); wait_done();

    for (int i = 0; i < 8; i++) begin
      go(2'($urandom_range(3)), $urandom, (i == 5) ? 32'd0 : $urandom >> (i * 3));
      wait_done();
    end

    @(negedge clk) mthi_we = 1'b1; wdata = 32'hAAAA0000;
    @(posedge clk) #1 mthi_we = 1'b0;
    chk("mthi", {32'b0, hi}, {32'b0, 32'hAAAA0000});
    old_lo = lo;
    mtlo_we = 1'b1; wdata = 32'h55;
    go(2'b01, 32'd2, 32'd3);
    mtlo_we = 1'b0;
    chk("mtlo_dropped", {32'b0, lo}, {32'b0, old_lo});
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd1; mthi_we = 1'b1; wdata = 32'hDEAD;
    @(posedge clk) #1 start = 1'b0; mthi_we = 1'b0;
    chk("hi_hold_run", {32'b0, hi}, {32'b0, 32'hAAAA0000});
    wait_done();
    chk("interference", {hi, lo}, 64'h00000000_00000006);
    @(negedge clk) chk("no_extra_done", {63'b0, done}, 64'd0);

    mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'h13579BDF;
    @(posedge clk) #1 mthi_we = 1'b0; mtlo_we = 1'b0;
    chk("mthi_mtlo", {hi, lo}, 64'h13579BDF_13579BDF);

    go(2'b01, 32'h1234, 32'h5678);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset", {hi, lo, 30'b0, busy, done}, 96'd0);
    sb_q.delete();
    @(negedge clk) rst = 1'b0;
    go(2'b01, 32'd7, 32'd6); wait_done();
    chk("after_reset", {32'b0, lo}, 64'd42);

    repeat (2) @(negedge clk);
    chk("queue_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
Iterative multiply/divide unit holding the MIPS HI/LO architectural registers. It serves MULT, MULTU, DIV, DIVU, MTHI and MTLO. Its hi/lo outputs feed the 32-bit 2:1 result mux that picks the MFHI/MFLO value for writeback. The pipeline control stalls on busy.

Parameters:
WIDTH, 32, operand/HI/LO width (only 32 is verified)
ITER, 32, iterations per multiply/divide (equals WIDTH)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  launch operation in op using a, b; sampled only when idle
op  input  2  2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU
a  input  32  rs operand (multiplicand / dividend)
b  input  32  rt operand (multiplier / divisor)
mthi_we  input  1  write wdata to HI (idle only)
mtlo_we  input  1  write wdata to LO (idle only)
wdata  input  32  MTHI/MTLO data
hi  output  32  HI register
lo  output  32  LO register
busy  output  1  operation in progress; pipeline stalls MFHI/MFLO/new MDU ops
done  output  1  one-cycle pulse when HI/LO have just been updated by an operation

Behaviour:
- Clocking and reset: one clock; rst is asynchronous, active-high. On reset, hi=0, lo=0, busy=0, done=0, FSM=IDLE, and internal accumulators and counter are cleared. Reset mid-operation aborts the operation; HI/LO read 0 afterwards.
- FSM states: IDLE, RUN, FIX.
  - IDLE + start at edge E0: latch op, absolute values of a and b (signed ops) or raw values (unsigned ops), and the operand signs; count=0; go to RUN; busy=1 from E0.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per edge. After the ITER-th step (edge E32), go to FIX.
  - FIX (edge E33): apply sign correction and write HI/LO. done=1 for the cycle after E33; busy=0 after E33; go to IDLE. A new start is accepted at the same edge done is seen high, i.e. E34.
- Latency: 34 edges from start to HI/LO valid, fixed, independent of operand values.
- Multiply: 64-bit product, {HI,LO}. Signed result is negated when sign(a) XOR sign(b).
- Divide: LO = quotient, HI = remainder. Signed quotient is negated when signs differ. The remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps, no trap).
- Divide by zero (b==0, DIV or DIVU): full 34-cycle latency. LO=0xFFFFFFFF, HI=a (raw dividend), no sign correction.
- start while busy is ignored. The operation in flight is unaffected.
- MTHI/MTLO write at the edge only when IDLE and start=0. When busy, or when start is asserted in the same cycle, they are ignored and start wins. mthi_we and mtlo_we together write both registers.
- hi and lo hold their old values throughout RUN/FIX until the FIX edge.
- op values are all defined; there are no illegal encodings.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done pulse exactly 34 edges after start; HI=0xFFFFFFFE, LO=0x00000001; busy high for 34 cycles.
- MULT a=0xFFFFFFFD (-3), b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=100, b=7 -> LO=0x0000000E, HI=0x00000002. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU a=0x12345678, b=0 -> LO=0xFFFFFFFF, HI=0x12345678 after 34 edges. Repeat with DIV a=0x80000001, b=0 -> LO=0xFFFFFFFF, HI=0x80000001.
- Interference: mthi_we with wdata=0xAAAA0000 while idle -> HI=0xAAAA0000 next edge. Then start MULTU 2*3 with mtlo_we asserted in the same cycle -> mtlo dropped. Second start pulse mid-RUN -> ignored. Final HI=0, LO=6.
- Assert rst asynchronously mid-RUN (cycle 10) -> hi=lo=0, busy=0, done=0 immediately. A subsequent MULTU 7*6 after release gives LO=42.
